ln_psum_fabric: RTL

LN_PSUM_FABRIC -- requirements
Module: ln_psum_fabric

---
 rtl/ln_psum_fabric.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ln_psum_fabric.sv
// Local-network psum fabric: per-column link FIFOs carry psums from row r+1 down into row r,
// otherwise PEs pass through to GIN/GON. Define LN_LINK_STATS_EN to add per-link pop counters.
module ln_psum_fabric #(
  parameter int NUM_ROWS   = 6,
  parameter int NUM_COLS   = 8,
  parameter int DATA_BITS  = 32,
  parameter int LINK_DEPTH = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   set_LN,
  input  logic [NUM_ROWS-2:0]                    LN_config_in,
  input  logic                                   flush,
  input  logic [NUM_ROWS*NUM_COLS*DATA_BITS-1:0] pe_opsum_data,
  input  logic [NUM_ROWS*NUM_COLS-1:0]           pe_opsum_valid,
  output logic [NUM_ROWS*NUM_COLS-1:0]           pe_opsum_ready,
  output logic [NUM_ROWS*NUM_COLS*DATA_BITS-1:0] pe_ipsum_data,
  output logic [NUM_ROWS*NUM_COLS-1:0]           pe_ipsum_valid,
  input  logic [NUM_ROWS*NUM_COLS-1:0]           pe_ipsum_ready,
  input  logic [DATA_BITS-1:0]                   gin_ipsum_data,
  input  logic [NUM_ROWS*NUM_COLS-1:0]           gin_ipsum_valid,
  output logic [NUM_ROWS*NUM_COLS-1:0]           gin_ipsum_ready,
  output logic [NUM_ROWS*NUM_COLS-1:0]           gon_opsum_valid,
  input  logic [NUM_ROWS*NUM_COLS-1:0]           gon_opsum_ready,
  output logic [NUM_ROWS-2:0]                    LN_config,
  output logic                                   ln_cfg_err,
`ifdef LN_LINK_STATS_EN
  output logic [(NUM_ROWS-1)*NUM_COLS*16-1:0]    link_count,
`endif
  output logic                                   links_empty
);

  localparam int unsigned NL    = (NUM_ROWS > 1) ? NUM_ROWS - 1 : 1;
  localparam int unsigned NLK   = NL * NUM_COLS;
  localparam int unsigned NLINK = NUM_ROWS - 1;
  localparam int unsigned NC    = NUM_COLS;
  localparam int unsigned PTR_W = $clog2(LINK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NLK-1:0]       full, empty, push, pop, nz_nxt;
  logic [DATA_BITS-1:0] head [NLK];

  // Row 0 opsum always leaves through GON, so its data never enters a link.
  logic unused_row0_data;
  assign unused_row0_data = ^pe_opsum_data[NUM_COLS*DATA_BITS-1:0];

  always_comb begin
    gon_opsum_valid = pe_opsum_valid;
    pe_opsum_ready  = gon_opsum_ready;
    pe_ipsum_valid  = gin_ipsum_valid;
    gin_ipsum_ready = pe_ipsum_ready;
    push            = '0;
    pop             = '0;
    for (int unsigned p = 0; p < NUM_ROWS * NC; p++)
      pe_ipsum_data[p*DATA_BITS +: DATA_BITS] = gin_ipsum_data;
    for (int unsigned r = 0; r < NLINK; r++) begin
      for (int unsigned c = 0; c < NC; c++) begin
        if (LN_config[r]) begin
          pe_opsum_ready[(r+1)*NC+c]  = !full[r*NC+c];
          gon_opsum_valid[(r+1)*NC+c] = 1'b0;
          push[r*NC+c] = pe_opsum_valid[(r+1)*NC+c] && !full[r*NC+c];
          pe_ipsum_valid[r*NC+c]  = !empty[r*NC+c];
          gin_ipsum_ready[r*NC+c] = 1'b0;
          pe_ipsum_data[(r*NC+c)*DATA_BITS +: DATA_BITS] = head[r*NC+c];
          pop[r*NC+c] = !empty[r*NC+c] && pe_ipsum_ready[r*NC+c];
        end
      end
    end
  end

  if (NUM_ROWS > 1) begin : g_links
    for (genvar l = 0; l < NLK; l++) begin : g_link
      logic [DATA_BITS-1:0] mem [LINK_DEPTH];
      logic [PTR_W-1:0]     wptr, rptr;
      logic [CNT_W-1:0]     cnt, cnt_nxt;

      assign full[l]  = (cnt == CNT_W'(LINK_DEPTH));
      assign empty[l] = (cnt == '0);
      assign head[l]  = mem[rptr];

      always_comb begin
        cnt_nxt = cnt;
        if (flush)                    cnt_nxt = '0;
        else if (push[l] && !pop[l])  cnt_nxt = cnt + CNT_W'(1);
        else if (!push[l] && pop[l])  cnt_nxt = cnt - CNT_W'(1);
        nz_nxt[l] = (cnt_nxt != '0);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wptr <= '0;
          rptr <= '0;
          cnt  <= '0;
        end else begin
          cnt <= cnt_nxt;
          if (flush) begin
            wptr <= '0;
            rptr <= '0;
          end else begin
            if (push[l]) wptr <= wptr + PTR_W'(1);
            if (pop[l])  rptr <= rptr + PTR_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (push[l] && !flush)
          mem[wptr] <= pe_opsum_data[(l+NUM_COLS)*DATA_BITS +: DATA_BITS];
      end

`ifdef LN_LINK_STATS_EN
      logic [15:0] stat;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                        stat <= '0;
        else if (flush)                 stat <= '0;
        else if (pop[l] && stat != '1)  stat <= stat + 16'd1;
      end
      assign link_count[l*16 +: 16] = stat;
`endif
    end
  end else begin : g_no_links
    assign full   = '0;
    assign empty  = '1;
    assign nz_nxt = '0;
    for (genvar l = 0; l < NLK; l++) begin : g_head
      assign head[l] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LN_config   <= '0;
      ln_cfg_err  <= 1'b0;
      links_empty <= 1'b1;
    end else begin
      links_empty <= ~|nz_nxt;
      ln_cfg_err  <= 1'b0;
      if (set_LN) begin
        if (links_empty && !flush) LN_config  <= LN_config_in;
        else                       ln_cfg_err <= 1'b1;
      end
    end
  end

endmodule
